// File: rtl/iir_pkg.sv
// Shared types and constants for the time-multiplexed biquad and its DSP48A1-style MAC.
// The OPMODE select codes follow the DSP48A1 X/Z multiplexer encoding.
package iir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_WAIT,
        ST_STORE,
        ST_DONE
    } state_t;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    localparam int MAC_TAPS = 5;
    localparam int PIPE_LAT = 2;

    localparam logic [1:0] OPMODE_X_ZERO = 2'b00;
    localparam logic [1:0] OPMODE_X_M    = 2'b01;
    localparam logic [1:0] OPMODE_Z_ZERO = 2'b00;
    localparam logic [1:0] OPMODE_Z_P    = 2'b10;

endpackage

// File: rtl/module_iir_biquad_if.sv
// Sample and coefficient port bundle of the biquad; master drives samples/coefficients,
// slave is the filter.
interface module_iir_biquad_if #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int NCH    = 2
);
    logic                    sample_in_rdy;
    logic [NCH*DATA_W-1:0]   sample_in;
    logic                    coef_wr;
    logic [2:0]              coef_addr;
    logic [COEF_W-1:0]       coef_data;
    logic                    coef_commit;
    logic                    busy;
    logic                    sample_drop;
    logic                    sample_out_rdy;
    logic [NCH*DATA_W-1:0]   sample_out;

    modport master (
        output sample_in_rdy, sample_in, coef_wr, coef_addr, coef_data, coef_commit,
        input  busy, sample_drop, sample_out_rdy, sample_out
    );

    modport slave (
        input  sample_in_rdy, sample_in, coef_wr, coef_addr, coef_data, coef_commit,
        output busy, sample_drop, sample_out_rdy, sample_out
    );
endinterface

// File: rtl/iir_mac.sv
// Behavioural DSP48A1 slice: registered multiply (M) then registered add/sub/load (P),
// two cycles from operands to P.
module iir_mac
    import iir_pkg::*;
#(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    input  logic [1:0]              i_opmode_x,
    input  logic [1:0]              i_opmode_z,
    input  logic                    i_sub,
    output logic signed [ACC_W-1:0] o_p
);
    localparam int PROD_W = A_W + B_W;

    logic signed [PROD_W-1:0] r_m;
    logic [1:0]               r_opx;
    logic [1:0]               r_opz;
    logic                     r_sub;
    logic signed [ACC_W-1:0]  r_p;
    logic signed [ACC_W-1:0]  w_x;
    logic signed [ACC_W-1:0]  w_z;

    // Opmode travels with the product so it is applied in the same stage as M.
    always_comb begin
        w_x = (r_opx == OPMODE_X_M) ? {{(ACC_W-PROD_W){r_m[PROD_W-1]}}, r_m} : '0;
        w_z = (r_opz == OPMODE_Z_P) ? r_p : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m   <= '0;
            r_opx <= OPMODE_X_ZERO;
            r_opz <= OPMODE_Z_P;
            r_sub <= 1'b0;
            r_p   <= '0;
        end else begin
            r_m   <= i_a * i_b;
            r_opx <= i_opmode_x;
            r_opz <= i_opmode_z;
            r_sub <= i_sub;
            r_p   <= r_sub ? (w_z - w_x) : (w_z + w_x);
        end
    end

    assign o_p = r_p;
endmodule

// File: rtl/module_iir_biquad.sv
// Time-multiplexed Direct Form I biquad for NCH channels sharing one MAC and one coefficient set.
// Build option IIR_SATURATE_EN: clamp results to DATA_W instead of two's-complement wrap.
module module_iir_biquad
    import iir_pkg::*;
#(
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int FRAC_BITS = 16,
    parameter int NCH       = 2,
    parameter int ACC_W     = 48
) (
    input logic                clk,
    input logic                reset,
    module_iir_biquad_if.slave bus
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    typedef logic signed [DATA_W-1:0] samp_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    localparam coef_t COEF_ONE = COEF_W'(1 << FRAC_BITS);
`ifdef IIR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    state_t                  r_state;
    logic [2:0]              r_cnt;
    logic [CH_W-1:0]         r_ch;
    logic                    r_pend;
    logic                    r_busy;
    logic                    r_drop;
    logic                    r_out_rdy;
    logic [NCH*DATA_W-1:0]   r_out;
    coef_t                   r_shadow [MAC_TAPS];
    coef_t                   r_active [MAC_TAPS];
    coef_t                   w_shadow_nxt [MAC_TAPS];
    samp_t                   r_xin [NCH];
    samp_t                   r_x1 [NCH];
    samp_t                   r_x2 [NCH];
    samp_t                   r_y1 [NCH];
    samp_t                   r_y2 [NCH];
    samp_t                   r_res [NCH];
    logic [2:0]              w_tap;
    samp_t                   w_data;
    coef_t                   w_coef;
    logic [1:0]              w_opx;
    logic [1:0]              w_opz;
    logic                    w_sub;
    logic signed [ACC_W-1:0] w_p;
    logic signed [ACC_W-1:0] w_shift;
    samp_t                   w_res;

    // A write in the same cycle as a commit must be part of what gets committed.
    always_comb begin
        for (int i = 0; i < MAC_TAPS; i++) w_shadow_nxt[i] = r_shadow[i];
        if (bus.coef_wr && bus.coef_addr <= TAP_A2) w_shadow_nxt[bus.coef_addr] = bus.coef_data;
    end

    always_comb begin
        w_tap  = TAP_A2 - r_cnt;
        w_coef = r_active[w_tap];
        case (w_tap)
            TAP_B0:  w_data = r_xin[r_ch];
            TAP_B1:  w_data = r_x1[r_ch];
            TAP_B2:  w_data = r_x2[r_ch];
            TAP_A1:  w_data = r_y1[r_ch];
            default: w_data = r_y2[r_ch];
        endcase
        w_opx = OPMODE_X_ZERO;
        w_opz = OPMODE_Z_P;
        w_sub = 1'b0;
        if (r_state == ST_MAC) begin
            w_opx = OPMODE_X_M;
            w_opz = (w_tap == TAP_B0) ? OPMODE_Z_ZERO : OPMODE_Z_P;
            w_sub = (w_tap >= TAP_A1);
        end
    end

    iir_mac #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
        .clk        (clk),
        .rst        (reset),
        .i_a        (w_data),
        .i_b        (w_coef),
        .i_opmode_x (w_opx),
        .i_opmode_z (w_opz),
        .i_sub      (w_sub),
        .o_p        (w_p)
    );

    always_comb begin
        w_shift = w_p >>> FRAC_BITS;
`ifdef IIR_SATURATE_EN
        if (w_shift > SAT_HI)      w_res = DATA_W'(SAT_HI);
        else if (w_shift < SAT_LO) w_res = DATA_W'(SAT_LO);
        else                       w_res = DATA_W'(w_shift);
`else
        w_res = DATA_W'(w_shift);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ch      <= '0;
            r_pend    <= 1'b0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
            r_out_rdy <= 1'b0;
            r_out     <= '0;
            for (int i = 0; i < MAC_TAPS; i++) begin
                r_shadow[i] <= (i == 0) ? COEF_ONE : '0;
                r_active[i] <= (i == 0) ? COEF_ONE : '0;
            end
            for (int c = 0; c < NCH; c++) begin
                r_xin[c] <= '0;
                r_x1[c]  <= '0;
                r_x2[c]  <= '0;
                r_y1[c]  <= '0;
                r_y2[c]  <= '0;
                r_res[c] <= '0;
            end
        end else begin
            r_drop    <= bus.sample_in_rdy && (r_state != ST_IDLE);
            r_out_rdy <= 1'b0;
            for (int i = 0; i < MAC_TAPS; i++) r_shadow[i] <= w_shadow_nxt[i];
            if (bus.coef_commit && r_state != ST_IDLE && r_state != ST_DONE) r_pend <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (bus.coef_commit)
                        for (int i = 0; i < MAC_TAPS; i++) r_active[i] <= w_shadow_nxt[i];
                    if (bus.sample_in_rdy) begin
                        for (int c = 0; c < NCH; c++) r_xin[c] <= bus.sample_in[c*DATA_W +: DATA_W];
                        r_ch    <= '0;
                        r_cnt   <= 3'(MAC_TAPS - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (r_cnt == 3'd0) begin
                        r_cnt   <= 3'(PIPE_LAT - 1);
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd0) r_state <= ST_STORE;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                ST_STORE: begin
                    r_res[r_ch] <= w_res;
                    r_x2[r_ch]  <= r_x1[r_ch];
                    r_x1[r_ch]  <= r_xin[r_ch];
                    r_y2[r_ch]  <= r_y1[r_ch];
                    r_y1[r_ch]  <= w_res;
                    if (r_ch == CH_W'(NCH - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_cnt   <= 3'(MAC_TAPS - 1);
                        r_state <= ST_MAC;
                    end
                end
                ST_DONE: begin
                    for (int c = 0; c < NCH; c++) r_out[c*DATA_W +: DATA_W] <= r_res[c];
                    r_out_rdy <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                    if (r_pend || bus.coef_commit)
                        for (int i = 0; i < MAC_TAPS; i++) r_active[i] <= w_shadow_nxt[i];
                    r_pend <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.sample_drop    = r_drop;
    assign bus.sample_out_rdy = r_out_rdy;
    assign bus.sample_out     = r_out;
endmodule

// File: doc/module_iir_biquad.md
# module_iir_biquad

- Parametrised, time-multiplexed second-order IIR (biquad, Direct Form I) filter for NCH audio channels.
- Uses one multiply-accumulate pipeline that models DSP48A1 behaviour: M register and P register, two-cycle latency.
- Sits between the voice mixer and the output stage, in the slot previously held by the single-channel LPF.
- Coefficients are written at run time through a shadow bank and committed atomically at sample boundaries.

## Interface
- DATA_W, 18, sample width (signed).
- COEF_W, 18, coefficient width (signed, Q2.FRAC_BITS).
- FRAC_BITS, 16, coefficient fraction bits; 1.0 = 1<<FRAC_BITS.
- NCH, 2, channel count (1..8).
- ACC_W, 48, accumulator width.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_in_rdy  in  1  one-cycle strobe; all channels valid.
- sample_in  in  NCH*DATA_W  packed signed samples, ch0 in LSBs.
- coef_wr  in  1  write coef_data into shadow slot coef_addr.
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored.
- coef_data  in  COEF_W  signed coefficient.
- coef_commit  in  1  request shadow→active copy.
- busy  out  1  high from capture until DONE.
- sample_drop  out  1  one-cycle pulse: strobe arrived while busy.
- sample_out_rdy  out  1  one-cycle strobe.
- sample_out  out  NCH*DATA_W  packed filtered samples.

## Operation
- Filter equation, per channel c: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2. Coefficients are shared by all channels. Delay lines x1, x2, y1, y2 are kept per channel.
- FSM states: IDLE, MAC, WAIT, STORE, DONE.
  - IDLE: on sample_in_rdy, latch sample_in, set ch=0, go to MAC.
  - MAC: 5 cycles, tap 0..4 (x, x1, x2, y1, y2). Tap 0 loads the accumulator; taps 1..4 add (taps 3 and 4 subtract). Then go to WAIT.
  - WAIT: 2 cycles, pipeline drain.
  - STORE: r = acc >>> FRAC_BITS, then saturate/wrap to DATA_W. Write r to the output slot ch. Shift x2←x1←x, y2←y1←r. If ch==NCH−1, go to DONE; otherwise ch++ and go to MAC.
  - DONE: register sample_out and assert sample_out_rdy; go to IDLE.
- Arithmetic:
  - Products are DATA_W+COEF_W signed, sign-extended to ACC_W.
  - The shift is arithmetic, i.e. it truncates toward −∞.
  - No rounding.
- Coefficient banks:
  - Shadow bank: written any cycle.
  - Active bank: updated only when coef_commit is seen in IDLE, or by a pending commit applied in the DONE cycle. A commit requested while busy sets a pending flag.
  - If coef_wr and coef_commit occur in the same cycle, the write lands first and is included in the commit.
- Reset values:
  - Active and shadow banks: b0=1<<FRAC_BITS, all others 0 (passthrough).
  - Delay lines: 0.
  - All outputs: 0.
  - FSM state: IDLE.
- Boundary conditions:
  - sample_in_rdy while busy is ignored and pulses sample_drop the next cycle. State is not disturbed.
  - sample_in_rdy in the DONE cycle is also dropped.
  - Reset mid-operation aborts immediately. Delay lines, pending commit and outputs are cleared, and no sample_out_rdy is emitted.

## Timing
- Let capture be cycle 0.
- Channel c occupies cycles 1+8c..8+8c: MAC 1+8c..5+8c, WAIT 6+8c..7+8c, STORE 8+8c.
- DONE is at cycle 8·NCH+1. sample_out_rdy is high at cycle 8·NCH+2 (18 for NCH=2) for exactly one cycle.
- busy is high for cycles 1..8·NCH+1.
- The maximum input rate is one strobe per 8·NCH+2 cycles.
- sample_out holds its value until the next DONE.

## Configuration
- IIR_SATURATE_EN.
  - Defined: the STORE result clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. The value stored in y1 is the clamped value.
  - Undefined: the result is truncated to the low DATA_W bits (two's-complement wrap). This saves logic.

## Structure
- Package iir_pkg holds:
  - the FSM state enum;
  - tap index constants (TAP_B0..TAP_A2);
  - localparams MAC_TAPS=5 and PIPE_LAT=2;
  - the OPMODE X/Z select constants shared with other DSP48A1-based blocks.
- Sub-module iir_mac: registered multiply (M) and registered accumulate/load/subtract (P), two-cycle latency. It maps directly onto DSP48A1; a behavioural model is used for simulation.

## Test plan
- Reset passthrough: after reset, input ch0=0x01234 and ch1=−0x01000 → outputs are identical, at cycle 18.
- Impulse: set b0=0x08000, a1=−0x08000 (y=0.5x+0.5y1) and commit. Feed 0x10000, then zeros → ch0 outputs 0x08000, 0x04000, 0x02000, 0x01000.
- Saturation: b0=0x1FFFF, input 0x1FFFF.
  - With the macro: output 0x1FFFF.
  - Without the macro: the wrapped low 18 bits of (b0·x)>>>16.
- Deferred commit: commit issued at cycle 5 of a run. That sample uses the old coefficients; the next sample uses the new ones.
- Drop: second strobe at cycle 10 → sample_drop pulses at cycle 11; the first result is unaffected; only one sample_out_rdy.
- Reset at cycle 9 → no sample_out_rdy, outputs 0. The next sample uses cleared delay lines.
